score_hex_display: RTL and testbench
====================================

// Module: score_hex_display
// PURPOSE
//  Parametrised successor to the fixed four-digit HEX drivers and hand-wired sign/hundreds segments in the top level.
//  Converts a binary score to decimal with a sequential double-dabble engine.
//  Drives NUM_DIGITS seven-segment displays with leading-zero blanking, overflow dashes and an optional minus sign.
//  Sits between the game/SoC score export and the HEX0..HEX(N-1) pins.
// PARAMETERS
//  DATA_W      16  width of input value; legal range 4..32
//  NUM_DIGITS  6   number of seven-segment digits driven; legal range 1..8
//  ACTIVE_LOW  1   1: segment/DP bits are 0=lit (DE10-Lite); 0: 1=lit
// PORTS
//  Clk       in   1                 system clock
//  Reset     in   1                 asynchronous, active-high reset
//  load      in   1                 request conversion of value (single-cycle strobe)
//  value     in   DATA_W            binary score sampled when the load is accepted
//  busy      out  1                 conversion in progress
//  done      out  1                 one-cycle pulse; hex_out updated this cycle
//  overflow  out  1                 last result did not fit in NUM_DIGITS
//  hex_out   out  NUM_DIGITS*8      digit i = [8i+7:8i]; bit7=DP (always off), [6:0]=g..a
// BEHAVIOUR
//  Reset state:
//  - busy=0, done=0, overflow=0; pending flag cleared; FSM in IDLE.
//  - hex_out = all digits blank (all bits 1 if ACTIVE_LOW, else 0).
//  FSM IDLE -> CONVERT -> UPDATE -> IDLE:
//  - IDLE: load=1 at edge N captures value; CONVERT starts; busy=1 from N+1.
//  - CONVERT: one shift-add-3 step per edge, DATA_W edges (N+1..N+DATA_W); 5-bit step counter.
//  - UPDATE: at edge N+DATA_W+1, hex_out and overflow are registered, done=1 for one cycle, busy=0, state returns to IDLE.
//  - Latency from load edge to display change is DATA_W+1 cycles; hex_out holds its old value throughout (no flicker).
//  Load while busy:
//  - Stored in a one-deep pending buffer; the latest value wins.
//  - The pending value is accepted at the first IDLE edge after UPDATE, i.e. 1 cycle after done.
//  - A direct load in IDLE overrides and clears any pending value.
//  BCD width: BCD_D = (DATA_W*3)/10 + 2 nibbles; shift register width = BCD_D*4 + DATA_W.
//  Blanking:
//  - Digits above the most-significant nonzero BCD digit are blank.
//  - value 0 shows "0" in digit 0 only.
//  Overflow (any nonzero BCD digit at index >= NUM_DIGITS):
//  - Every digit shows a dash (segment g only) and overflow=1.
//  - The next in-range result clears overflow.
//  Segment map: standard 0-9 glyphs (a=bit0); BCD values >9 never occur and map to blank.
//  Reset during CONVERT/UPDATE aborts immediately to the reset state; the pending value is lost.
// CONFIGURATION
//  Macro SCORE_DISPLAY_SIGNED_EN:
//  - Defined: value is two's complement and the magnitude is converted (-2^(DATA_W-1) handled by unsigned DATA_W magnitude).
//  - Defined: negative results place a minus (g only) in the digit directly left of the MS digit.
//  - Defined: if no free digit exists for the minus, the result is overflow (all dashes).
//  - Undefined: value is unsigned; no sign logic is synthesised.
// STRUCTURE
//  Package score_display_pkg:
//  - state_t enum {IDLE, CONVERT, UPDATE}
//  - SEG_BLANK, SEG_DASH constants
//  - function seg7(input [3:0] bcd) returning active-high [6:0]
//  Polarity: ACTIVE_LOW inversion is applied once at the hex_out register input.
//  Sub-module bin2bcd_seq:
//  - Owns the double-dabble shift register and step counter.
//  - Ports: Clk, Reset, start, bin, bcd, valid.
//  - Top owns the FSM, pending buffer, blanking/overflow/sign and segment encoding.
// TESTING
//  Unsigned, DATA_W=16, NUM_DIGITS=6, ACTIVE_LOW=1.
//  1. load value=1234 -> done 17 cycles later; digits 5..4 = 8'hFF, digits 3..0 = "1","2","3","4"; overflow=0.
//  2. load value=0 -> digit0 = "0" (8'hC0), digits 5..1 = 8'hFF.
//  3. DATA_W=20, load value=1000000 -> all six digits 8'hBF (dash), overflow=1.
//     Then load 7 -> overflow=0, digit0 = "7".
//  4. load 5 at edge 0, load 7 at edge 3, load 9 at edge 4:
//     - done at edge 17 shows "5".
//     - Second conversion starts at edge 18; done at edge 35 shows "9"; 7 never displayed.
//  5. Assert Reset at edge 8 of a conversion:
//     - busy=0, hex_out all 8'hFF immediately.
//     - No done pulse follows; the next load works normally.
//  6. SCORE_DISPLAY_SIGNED_EN, NUM_DIGITS=6, load -42 -> "   -42".
//     NUM_DIGITS=2, load -42 -> both dashes, overflow=1.

Source files
------------

// File: rtl/score_hex_display_pkg.sv
// Shared types and segment helpers for the score seven-segment display.
//   state_t   : controller states IDLE -> CONVERT -> UPDATE
//   SEG_BLANK : active-high pattern with every segment off
//   SEG_DASH  : active-high pattern with segment g only
//   seg7()    : BCD digit to active-high g..a pattern (a = bit 0)
package score_display_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      UPDATE  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;

   // Codes above 9 cannot come out of the converter; they map to blank.
   function automatic logic [6:0] seg7(input logic [3:0] bcd);
      logic [6:0] s;
      case (bcd)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/score_hex_display_if.sv
// Score display bus.
//   load      : request conversion of value (single-cycle strobe)
//   value     : binary score, sampled when the load is accepted
//   busy      : conversion in progress
//   done      : one-cycle pulse, hex_out updated this cycle
//   overflow  : last result did not fit in NUM_DIGITS
//   hex_out   : digit i = [8i+7:8i], bit7 = DP, [6:0] = g..a
//   fsm_state : controller state, for observation only
// Handshake: load is a strobe with no ready; a load seen while busy is kept in
// a one-deep buffer (latest wins) and started once the controller is idle, so
// no request is dropped except one that is overwritten by a newer one.
// master = score source, slave = display controller.
interface score_hex_display_if
   import score_display_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int NUM_DIGITS = 6
);
   logic                    load;
   logic [DATA_W-1:0]       value;
   logic                    busy;
   logic                    done;
   logic                    overflow;
   logic [NUM_DIGITS*8-1:0] hex_out;
   state_t                  fsm_state;

   modport master (output load, value,
                   input  busy, done, overflow, hex_out, fsm_state);
   modport slave  (input  load, value,
                   output busy, done, overflow, hex_out, fsm_state);
endinterface

// File: rtl/score_hex_display_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble binary to BCD converter.
//   Clk, Reset : clock, asynchronous active-high reset
//   start      : load bin and begin a conversion (one step per edge follows)
//   bin        : binary input, sampled on start
//   bcd        : BCD_D packed nibbles, complete once the last step has run
//   valid      : high during the cycle whose closing edge performs the last
//                step, so a controller can leave its convert state on that edge
module bin2bcd_seq #(
   parameter int DATA_W = 16,
   parameter int BCD_D  = (DATA_W * 3) / 10 + 2
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 start,
   input  logic [DATA_W-1:0]    bin,
   output logic [BCD_D*4-1:0]   bcd,
   output logic                 valid
);
   localparam int SR_W = BCD_D * 4 + DATA_W;

   logic [SR_W-1:0] sr;
   logic [SR_W-1:0] sr_adj;
   logic [4:0]      cnt;
   logic            running;

   // Add 3 to every BCD nibble that is 5 or more before the shift.
   always_comb begin
      sr_adj = sr;
      for (int d = 0; d < BCD_D; d++) begin
         if (sr[DATA_W + 4*d +: 4] >= 4'd5)
            sr_adj[DATA_W + 4*d +: 4] = sr[DATA_W + 4*d +: 4] + 4'd3;
      end
   end

   assign valid = running && (cnt == 5'(DATA_W - 1));
   assign bcd   = sr[SR_W-1 -: BCD_D*4];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sr      <= '0;
         cnt     <= '0;
         running <= 1'b0;
      end else if (start) begin
         sr      <= {{(BCD_D*4){1'b0}}, bin};
         cnt     <= '0;
         running <= 1'b1;
      end else if (running) begin
         sr  <= {sr_adj[SR_W-2:0], 1'b0};
         cnt <= cnt + 5'd1;
         if (valid)
            running <= 1'b0;
      end
   end
endmodule

// File: rtl/score_hex_display.sv
// score_hex_display: binary score to NUM_DIGITS seven-segment digits with
// leading-zero blanking, overflow dashes and (with SCORE_DISPLAY_SIGNED_EN
// defined) a minus sign for two's complement input.
//   Clk, Reset : clock, asynchronous active-high reset
//   bus        : score_hex_display_if.slave (load/value in; busy, done,
//                overflow, hex_out, fsm_state out)
// Configuration macro: SCORE_DISPLAY_SIGNED_EN.
module score_hex_display
   import score_display_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int NUM_DIGITS = 6,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                 Clk,
   input  logic                 Reset,
   score_hex_display_if.slave   bus
);
   localparam int BCD_D = (DATA_W * 3) / 10 + 2;
   localparam int MAXD  = (BCD_D > NUM_DIGITS) ? BCD_D : NUM_DIGITS;
   localparam logic [7:0] BLANK_BYTE = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

   state_t                  state, state_nxt;
   logic                    start;
   logic [DATA_W-1:0]       start_value, mag;
   logic                    pend_valid;
   logic [DATA_W-1:0]       pend_value;
   logic [BCD_D*4-1:0]      bcd;
   logic                    bcd_last;
   logic [MAXD*4-1:0]       bcd_pad;
   logic [3:0]              msd;
   logic                    big, ovf, neg;
   logic [6:0]              seg;
   logic [NUM_DIGITS*8-1:0] hex_nxt, hex_r;
   logic                    done_r, ovf_r;

   // A direct load wins over a buffered one.
   assign start_value = bus.load ? bus.value : pend_value;

`ifdef SCORE_DISPLAY_SIGNED_EN
   logic neg_r;
   // The most negative value negates to itself, which read as unsigned is
   // exactly its magnitude.
   assign mag = start_value[DATA_W-1] ? (~start_value + {{(DATA_W-1){1'b0}}, 1'b1})
                                      : start_value;
   assign neg = neg_r;
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         neg_r <= 1'b0;
      else if (start)
         neg_r <= start_value[DATA_W-1];
   end
`else
   assign mag = start_value;
   assign neg = 1'b0;
`endif

   bin2bcd_seq #(.DATA_W(DATA_W), .BCD_D(BCD_D)) u_bin2bcd (
      .Clk   (Clk),
      .Reset (Reset),
      .start (start),
      .bin   (mag),
      .bcd   (bcd),
      .valid (bcd_last)
   );

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.load || pend_valid) begin
               start     = 1'b1;
               state_nxt = CONVERT;
            end
         end
         CONVERT: if (bcd_last) state_nxt = UPDATE;
         UPDATE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Blanking, overflow and sign placement from the finished BCD result.
   always_comb begin
      bcd_pad = '0;
      bcd_pad[BCD_D*4-1:0] = bcd;
      msd = '0;
      big = 1'b0;
      for (int d = 0; d < MAXD; d++) begin
         if (bcd_pad[4*d +: 4] != 4'd0) begin
            msd = 4'(d);
            if (d >= NUM_DIGITS) big = 1'b1;
         end
      end
      // A minus needs a free digit left of the most significant one.
      ovf = big || (neg && (int'(msd) + 1 >= NUM_DIGITS));
      hex_nxt = '0;
      seg     = SEG_BLANK;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         seg = SEG_BLANK;
         if (ovf)
            seg = SEG_DASH;
         else if (i <= int'(msd))
            seg = seg7(bcd_pad[4*i +: 4]);
         else if (neg && (i == int'(msd) + 1))
            seg = SEG_DASH;
         hex_nxt[8*i +: 8] = (ACTIVE_LOW != 0) ? ~{1'b0, seg} : {1'b0, seg};
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         pend_valid <= 1'b0;
         pend_value <= '0;
         done_r     <= 1'b0;
         ovf_r      <= 1'b0;
         hex_r      <= {NUM_DIGITS{BLANK_BYTE}};
      end else begin
         state  <= state_nxt;
         done_r <= (state == UPDATE);
         if (state == UPDATE) begin
            hex_r <= hex_nxt;
            ovf_r <= ovf;
         end
         if (state != IDLE && bus.load) begin
            pend_valid <= 1'b1;
            pend_value <= bus.value;
         end else if (state == IDLE) begin
            pend_valid <= 1'b0;
         end
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_r;
   assign bus.overflow  = ovf_r;
   assign bus.hex_out   = hex_r;
   assign bus.fsm_state = state;
endmodule

// File: tb/tb_score_hex_display.sv
module tb_score_hex_display;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   score_hex_display_if #(.DATA_W(16), .NUM_DIGITS(6)) a ();
   score_hex_display_if #(.DATA_W(20), .NUM_DIGITS(6)) b ();

   score_hex_display #(.DATA_W(16), .NUM_DIGITS(6), .ACTIVE_LOW(1)) dut_a (
      .Clk(clk), .Reset(rst), .bus(a.slave));
   score_hex_display #(.DATA_W(20), .NUM_DIGITS(6), .ACTIVE_LOW(1)) dut_b (
      .Clk(clk), .Reset(rst), .bus(b.slave));

`ifdef SCORE_DISPLAY_SIGNED_EN
   score_hex_display_if #(.DATA_W(16), .NUM_DIGITS(2)) c ();
   score_hex_display #(.DATA_W(16), .NUM_DIGITS(2), .ACTIVE_LOW(1)) dut_c (
      .Clk(clk), .Reset(rst), .bus(c.slave));
`endif

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive a load strobe so it is sampled at the next rising edge; returns
   // at the falling edge after that edge.
   task automatic load_a(input logic [15:0] v);
      @(negedge clk); a.load = 1'b1; a.value = v;
      @(negedge clk); a.load = 1'b0;
   endtask

   task automatic load_b(input logic [19:0] v);
      @(negedge clk); b.load = 1'b1; b.value = v;
      @(negedge clk); b.load = 1'b0;
   endtask

   // Count rising edges until done is seen; -1 if the budget runs out.
   task automatic wait_a(output int n);
      n = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); @(negedge clk);
         if (a.done === 1'b1) begin n = k; break; end
      end
   endtask

   task automatic wait_b(output int n);
      n = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); @(negedge clk);
         if (b.done === 1'b1) begin n = k; break; end
      end
   endtask

`ifdef SCORE_DISPLAY_SIGNED_EN
   task automatic load_c(input logic [15:0] v);
      @(negedge clk); c.load = 1'b1; c.value = v;
      @(negedge clk); c.load = 1'b0;
   endtask

   task automatic wait_c(output int n);
      n = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); @(negedge clk);
         if (c.done === 1'b1) begin n = k; break; end
      end
   endtask
`endif

   initial begin
      int n;
      int dcnt;
      rst = 1'b1;
      a.load = 1'b0; a.value = '0;
      b.load = 1'b0; b.value = '0;
`ifdef SCORE_DISPLAY_SIGNED_EN
      c.load = 1'b0; c.value = '0;
`endif
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_busy", 64'(a.busy), 64'd0);
      chk("rst_done", 64'(a.done), 64'd0);
      chk("rst_ovf",  64'(a.overflow), 64'd0);
      chk("rst_hex",  64'(a.hex_out), 64'hFFFF_FFFF_FFFF);
      rst = 1'b0;

      // 1234: latency, blanking, no flicker while converting
      load_a(16'd1234);
      chk("t1_busy_early", 64'(a.busy), 64'd1);
      chk("t1_hex_hold", 64'(a.hex_out), 64'hFFFF_FFFF_FFFF);
      wait_a(n);
      chk("t1_latency", 64'(n), 64'd17);
      chk("t1_hex", 64'(a.hex_out), 64'hFFFF_F9A4_B099);
      chk("t1_ovf", 64'(a.overflow), 64'd0);
      chk("t1_busy_end", 64'(a.busy), 64'd0);
      @(negedge clk);
      chk("t1_done_pulse", 64'(a.done), 64'd0);

      // zero shows a single 0
      load_a(16'd0);
      wait_a(n);
      chk("t2_hex", 64'(a.hex_out), 64'hFFFF_FFFF_FFC0);

      // four nines
      load_a(16'd9999);
      wait_a(n);
      chk("t2b_hex", 64'(a.hex_out), 64'hFFFF_9090_9090);

      // 20-bit: exactly six digits, then overflow, then recovery
      load_b(20'd100000);
      wait_b(n);
      chk("t3_latency", 64'(n), 64'd21);
      chk("t3_hex_fit", 64'(b.hex_out), 64'hF9C0_C0C0_C0C0);
      chk("t3_ovf_fit", 64'(b.overflow), 64'd0);
      load_b(20'd1000000);
      wait_b(n);
      chk("t3_hex_ovf", 64'(b.hex_out), 64'hBFBF_BFBF_BFBF);
      chk("t3_ovf_set", 64'(b.overflow), 64'd1);
      load_b(20'd7);
      wait_b(n);
      chk("t3_ovf_clr", 64'(b.overflow), 64'd0);
      chk("t3_hex_7", 64'(b.hex_out), 64'hFFFF_FFFF_FFF8);

      // pending buffer: 5 at edge 0, 7 at edge 3, 9 at edge 4
      load_a(16'd5);
      @(negedge clk);
      @(negedge clk);
      a.load = 1'b1; a.value = 16'd7;
      @(negedge clk);
      a.value = 16'd9;
      @(negedge clk);
      a.load = 1'b0;
      wait_a(n);
      chk("t4_first_lat", 64'(n), 64'd13);
      chk("t4_first_hex", 64'(a.hex_out), 64'hFFFF_FFFF_FF92);
      chk("t4_busy_gap", 64'(a.busy), 64'd0);
      wait_a(n);
      chk("t4_second_lat", 64'(n), 64'd18);
      chk("t4_second_hex", 64'(a.hex_out), 64'hFFFF_FFFF_FF90);

      // reset in the middle of a conversion
      load_a(16'd4321);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t5_busy", 64'(a.busy), 64'd0);
      chk("t5_hex", 64'(a.hex_out), 64'hFFFF_FFFF_FFFF);
      chk("t5_ovf", 64'(a.overflow), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (a.done === 1'b1) dcnt++;
      end
      chk("t5_no_done", 64'(dcnt), 64'd0);
      load_a(16'd77);
      wait_a(n);
      chk("t5_relat", 64'(n), 64'd17);
      chk("t5_rehex", 64'(a.hex_out), 64'hFFFF_FFFF_F8F8);

`ifdef SCORE_DISPLAY_SIGNED_EN
      // -42 with room for the sign, and without
      load_a(16'hFFD6);
      wait_a(n);
      chk("t6_hex_neg", 64'(a.hex_out), 64'hFFFF_FFBF_99A4);
      chk("t6_ovf_neg", 64'(a.overflow), 64'd0);
      load_c(16'hFFD6);
      wait_c(n);
      chk("t6_hex_2dig", 64'(c.hex_out), 64'hBFBF);
      chk("t6_ovf_2dig", 64'(c.overflow), 64'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
